// File: rtl/pg_channel_sequencer.sv
// Pulse-generator channel sequencer: period counter, duty pulse, double-buffered config, burst/continuous runs.
// Optional IRQ output when PG_SEQ_IRQ_EN is defined (adds i_irq_clr / o_irq).
module pg_channel_sequencer #(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned BURST_W = 16
) (
  input  logic               i_clk,
  input  logic               i_res_n,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [CNT_W-1:0]   i_cfg_period,
  input  logic [CNT_W-1:0]   i_cfg_duty,
  input  logic [BURST_W-1:0] i_cfg_burst,
  input  logic               i_start,
  input  logic               i_stop,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_cnt,
  output logic               o_pulse,
  output logic               o_period_tick,
  output logic               o_done
`ifdef PG_SEQ_IRQ_EN
  ,
  input  logic               i_irq_clr,
  output logic               o_irq
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   pend_period, pend_duty, act_period, act_duty;
  logic [BURST_W-1:0] pend_burst, act_burst, rem;
  logic               pend_vld, act_vld, stop_req;

  logic running, boundary, last, start_go, cfg_acc, promote;

  always_comb begin
    running  = (state == RUN);
    boundary = running && (cnt == act_period);
    // A stop arriving on the boundary cycle itself ends the run right there.
    last     = boundary && (stop_req || i_stop || (rem == BURST_W'(1)));
    start_go = (state == IDLE) && i_start && act_vld && !i_stop;
    cfg_acc  = i_cfg_valid && !pend_vld;
    promote  = pend_vld && ((state == IDLE) || boundary);
  end

  always_ff @(posedge i_clk) begin
    if (!i_res_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pend_period <= '0;
      pend_duty   <= '0;
      pend_burst  <= '0;
      pend_vld    <= 1'b0;
      act_period  <= '0;
      act_duty    <= '0;
      act_burst   <= '0;
      act_vld     <= 1'b0;
      rem         <= '0;
      stop_req    <= 1'b0;
    end else begin
      if (cfg_acc) begin
        pend_period <= i_cfg_period;
        pend_duty   <= i_cfg_duty;
        pend_burst  <= i_cfg_burst;
        pend_vld    <= 1'b1;
      end
      if (promote) begin
        act_period <= pend_period;
        act_duty   <= pend_duty;
        act_burst  <= pend_burst;
        act_vld    <= 1'b1;
        pend_vld   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start_go) begin
            state    <= RUN;
            cnt      <= '0;
            rem      <= act_burst;
            stop_req <= 1'b0;
          end
        end
        RUN: begin
          if (boundary) begin
            cnt <= '0;
            if (last) begin
              state    <= IDLE;
              stop_req <= 1'b0;
            end else if (rem != '0) begin
              rem <= rem - BURST_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (i_stop) stop_req <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PG_SEQ_IRQ_EN
  always_ff @(posedge i_clk) begin
    if (!i_res_n)       o_irq <= 1'b0;
    else if (last)      o_irq <= 1'b1;
    else if (i_irq_clr) o_irq <= 1'b0;
  end
`endif

  assign o_cfg_ready   = !pend_vld;
  assign o_busy        = running;
  assign o_cnt         = cnt;
  assign o_pulse       = running && (cnt < act_duty);
  assign o_period_tick = boundary;
  assign o_done        = last;

endmodule

// File: tb/tb_pg_channel_sequencer.sv
// Bench for pg_channel_sequencer: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural model.
module tb_pg_channel_sequencer;
  localparam int CNT_W   = 24;
  localparam int BURST_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               res_n, cfg_valid, start, stop;
  logic [CNT_W-1:0]   cfg_period, cfg_duty;
  logic [BURST_W-1:0] cfg_burst;
  logic               cfg_ready, busy, pulse, tick, done;
  logic [CNT_W-1:0]   cnt;
`ifdef PG_SEQ_IRQ_EN
  logic irq_clr, irq;
`endif

  int checks = 0;
  int errors = 0;

  pg_channel_sequencer #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .i_clk(clk), .i_res_n(res_n),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_period(cfg_period), .i_cfg_duty(cfg_duty), .i_cfg_burst(cfg_burst),
    .i_start(start), .i_stop(stop),
    .o_busy(busy), .o_cnt(cnt), .o_pulse(pulse),
    .o_period_tick(tick), .o_done(done)
`ifdef PG_SEQ_IRQ_EN
    , .i_irq_clr(irq_clr), .o_irq(irq)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: channel described as "running / position in period / periods left".
  bit          m_ok = 1'b0;
  bit          m_run, m_stop, m_pend, m_act, m_irq;
  int unsigned m_cnt, m_period, m_duty, m_burst, m_left;
  int unsigned p_period, p_duty, p_burst;

  function automatic bit m_bnd();
    return m_run && (m_cnt == m_period);
  endfunction

  function automatic bit m_fin(input bit s);
    return m_bnd() && (m_stop || s || (m_left == 1));
  endfunction

  always @(posedge clk) begin
    bit bnd, fin, go, acc;
    int unsigned ob;
    if (!res_n) begin
      m_run = 0; m_stop = 0; m_pend = 0; m_act = 0; m_irq = 0;
      m_cnt = 0; m_period = 0; m_duty = 0; m_burst = 0; m_left = 0;
      p_period = 0; p_duty = 0; p_burst = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      bnd = m_bnd();
      fin = m_fin(stop);
      go  = !m_run && start && !stop && m_act;
      acc = cfg_valid && !m_pend;
      ob  = m_burst;
`ifdef PG_SEQ_IRQ_EN
      if (fin) m_irq = 1;
      else if (irq_clr) m_irq = 0;
`endif
      if (m_pend && (!m_run || bnd)) begin
        m_period = p_period; m_duty = p_duty; m_burst = p_burst;
        m_act = 1; m_pend = 0;
      end else if (acc) begin
        p_period = cfg_period; p_duty = cfg_duty; p_burst = cfg_burst;
        m_pend = 1;
      end
      if (go) begin
        m_run = 1; m_cnt = 0; m_left = ob; m_stop = 0;
      end else if (m_run) begin
        if (bnd) begin
          m_cnt = 0;
          if (fin) begin m_run = 0; m_stop = 0; end
          else if (m_left > 0) m_left--;
        end else begin
          m_cnt++;
          if (stop) m_stop = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("busy",  32'(busy),      32'(m_run));
      chk("cnt",   32'(cnt),       m_cnt);
      chk("pulse", 32'(pulse),     32'(m_run && (m_cnt < m_duty)));
      chk("tick",  32'(tick),      32'(m_bnd()));
      chk("done",  32'(done),      32'(m_fin(stop)));
      chk("ready", 32'(cfg_ready), 32'(!m_pend));
`ifdef PG_SEQ_IRQ_EN
      chk("irq",   32'(irq),       32'(m_irq));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    step();
    step();
    res_n = 1'b1;
  endtask

  task automatic cfg(input int unsigned p, input int unsigned d, input int unsigned b);
    int n = 0;
    while (!cfg_ready && n < 50) begin step(); n++; end
    if (!cfg_ready) chk("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1; cfg_period = CNT_W'(p); cfg_duty = CNT_W'(d); cfg_burst = BURST_W'(b);
    step();
    cfg_valid = 1'b0;
    step();
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin step(); n++; end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  logic [14:0] v_pulse, v_tick, v_done, v_busy;
  logic [5:0]  v_rdy;

  initial begin
    res_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_period = '0; cfg_duty = '0; cfg_burst = '0;
`ifdef PG_SEQ_IRQ_EN
    irq_clr = 1'b0;
`endif
    do_reset();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_pulse_tick_done", {29'd0, pulse, tick, done}, 32'd0);
    step();

    // Burst of three 5-cycle periods with 2 high cycles each.
    cfg(4, 2, 3);
    do_start();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      v_pulse[i] = pulse; v_tick[i] = tick; v_done[i] = done; v_busy[i] = busy;
    end
    chk("t1_pulse", 32'(v_pulse), 32'h0C63);
    chk("t1_tick",  32'(v_tick),  32'h4210);
    chk("t1_done",  32'(v_done),  32'h4000);
    chk("t1_busy",  32'(v_busy),  32'h7FFF);
    @(negedge clk);
    chk("t1_end_busy", 32'(busy), 32'd0);
    chk("t1_end_cnt", 32'(cnt), 32'd0);
    step();

    // Mid-period reconfiguration applies only after the current boundary.
    cfg(9, 5, 0);
    do_start();
    step(); step(); step();
    chk("t2_cnt3", 32'(cnt), 32'd3);
    cfg_valid = 1'b1; cfg_period = CNT_W'(3); cfg_duty = CNT_W'(1); cfg_burst = '0;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      v_rdy[i] = cfg_ready;
    end
    chk("t2_ready_low", 32'(v_rdy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v_pulse[i] = pulse; v_tick[i] = tick; v_rdy[i] = cfg_ready;
    end
    chk("t2_pulse", 32'(v_pulse[3:0]), 32'h1);
    chk("t2_tick",  32'(v_tick[3:0]),  32'h8);
    chk("t2_ready", 32'(v_rdy[3:0]),   32'hF);
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle();

    // Graceful stop finishes the current period.
    cfg(7, 3, 0);
    do_start();
    step(); step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      v_done[i] = done; v_tick[i] = tick;
    end
    chk("t3_done", 32'(v_done[4:0]), 32'h10);
    chk("t3_tick", 32'(v_tick[4:0]), 32'h10);
    chk("t3_cnt7", 32'(cnt), 32'd7);
    @(negedge clk);
    chk("t3_busy_after", 32'(busy), 32'd0);
    step();

    // Start without a config is ignored; period 0 gives 1-cycle periods.
    do_reset();
    do_start();
    @(negedge clk);
    chk("t4_noconfig_busy", 32'(busy), 32'd0);
    step();
    cfg(0, 1, 2);
    do_start();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      v_pulse[i] = pulse; v_tick[i] = tick; v_done[i] = done;
    end
    chk("t4_pulse", 32'(v_pulse[1:0]), 32'h3);
    chk("t4_tick",  32'(v_tick[1:0]),  32'h3);
    chk("t4_done",  32'(v_done[1:0]),  32'h2);
    @(negedge clk);
    chk("t4_busy_after", 32'(busy), 32'd0);
    step();

    // Reset mid-run aborts and clears the active config.
    cfg(9, 3, 0);
    do_start();
    step(); step(); step(); step(); step();
    chk("t5_cnt5", 32'(cnt), 32'd5);
    res_n = 1'b0;
    step();
    res_n = 1'b1;
    @(negedge clk);
    chk("t5_outs", {26'd0, busy, pulse, tick, done, cfg_ready, |cnt}, 32'h2);
    step();
    do_start();
    @(negedge clk);
    chk("t5_start_ignored", 32'(busy), 32'd0);
    step();

`ifdef PG_SEQ_IRQ_EN
    cfg(2, 1, 1);
    do_start();
    begin
      int n = 0;
      while (!done && n < 20) begin @(negedge clk); n++; end
      chk("t6_done_seen", 32'(done), 32'd1);
    end
    step();
    @(negedge clk);
    chk("t6_irq_set", 32'(irq), 32'd1);
    step(); step();
    @(negedge clk);
    chk("t6_irq_held", 32'(irq), 32'd1);
    step();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    @(negedge clk);
    chk("t6_irq_clr", 32'(irq), 32'd0);
    step();
`endif

    for (int i = 0; i < 3000; i++) begin
      res_n      = ($urandom_range(299) != 0);
      cfg_valid  = ($urandom_range(3) == 0);
      cfg_period = CNT_W'($urandom_range(5));
      cfg_duty   = CNT_W'($urandom_range(7));
      cfg_burst  = BURST_W'($urandom_range(3));
      start      = ($urandom_range(7) == 0);
      stop       = ($urandom_range(15) == 0);
`ifdef PG_SEQ_IRQ_EN
      irq_clr    = ($urandom_range(9) == 0);
`endif
      step();
    end
    res_n = 1'b1; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    step();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
